// File: rtl/decryption.sv
// decryption: iterative block decryptor, one inverse round per clock (inverse of `encryption`).
// Optional MAC verification is compiled in with `define MAC_CHECK_EN (adds e_mac / mac_ok).
module decryption #(
  parameter int N      = 8,
  parameter int ROUNDS = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] key,
  input  logic [N-1:0] e_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] d_data,
  output logic         out_valid,
`ifdef MAC_CHECK_EN
  input  logic [N-1:0] e_mac,
  output logic         mac_ok,
`endif
  input  logic         out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [N-1:0] LAST_RND = N'(ROUNDS - 1);
  localparam logic [N-1:0] N_W      = N'(N);

  state_e       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] s_q, s_d;
  logic [N-1:0] key_q, key_d;
  logic [N-1:0] d_q, d_d;

  logic [N-1:0]   rot_amt, rk, diff, round_res;
  logic [2*N-1:0] key_dbl;

  // Round i = cnt_q: s' = rotr(s - rk, 3) ^ rk, rk = rotl(key, i mod N) ^ i.
  always_comb begin
    rot_amt   = cnt_q % N_W;
    key_dbl   = {key_q, key_q} << rot_amt;
    rk        = key_dbl[2*N-1:N] ^ cnt_q;
    diff      = s_q - rk;
    round_res = {diff[2:0], diff[N-1:3]} ^ rk;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    key_d   = key_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = e_data;
          key_d   = key;
          cnt_d   = LAST_RND;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d = round_res;
        if (cnt_q == '0) begin
          d_d     = round_res;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      key_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      key_q   <= key_d;
      d_q     <= d_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d_data    = d_q;

`ifdef MAC_CHECK_EN
  logic [N-1:0] mac_q, mac_d;
  logic         mac_ok_q, mac_ok_d;

  // MAC is compared against the final-round plaintext as DONE is entered.
  always_comb begin
    mac_d    = mac_q;
    mac_ok_d = mac_ok_q;
    case (state_q)
      IDLE:    if (in_valid) mac_d = e_mac;
      RUN:     if (cnt_q == '0) mac_ok_d = (mac_q == (round_res ^ ~key_q));
      DONE:    if (out_ready) mac_ok_d = 1'b0;
      default: mac_ok_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mac_q    <= '0;
      mac_ok_q <= 1'b0;
    end else begin
      mac_q    <= mac_d;
      mac_ok_q <= mac_ok_d;
    end
  end

  assign mac_ok = mac_ok_q;
`endif

endmodule

// File: tb/tb_decryption.sv
// tb_decryption: scoreboard bench for decryption; expected plaintext comes from a forward encryption model.
module tb_decryption;
  localparam int N      = 8;
  localparam int ROUNDS = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] key = '0;
  logic [N-1:0] e_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] d_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef MAC_CHECK_EN
  logic [N-1:0] e_mac = '0;
  logic         mac_ok;
`endif

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] mon_exp;
  logic [N-1:0] last_mac;

  decryption #(.N(N), .ROUNDS(ROUNDS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key       (key),
    .e_data    (e_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_data    (d_data),
    .out_valid (out_valid),
`ifdef MAC_CHECK_EN
    .e_mac     (e_mac),
    .mac_ok    (mac_ok),
`endif
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [N-1:0] rotl_m(input logic [N-1:0] v, input int r);
    logic [N-1:0] o;
    for (int b = 0; b < N; b++) o[(b + r) % N] = v[b];
    return o;
  endfunction

  // Forward cipher, used to derive expected plaintexts.
  function automatic logic [N-1:0] enc(input logic [N-1:0] p, input logic [N-1:0] k);
    logic [N-1:0] s, r;
    s = p;
    for (int i = 0; i < ROUNDS; i++) begin
      r = rotl_m(k, i % N) ^ N'(i);
      s = rotl_m(s ^ r, 3) + r;
    end
    return s;
  endfunction

  // Scoreboard: every delivered word is popped and compared.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got d_data=%h, nothing expected", d_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (d_data !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard_data: got d_data=%h, expected %h", d_data, mon_exp);
        end
      end
    end
  end

  task automatic drive_word(input logic [N-1:0] k, input logic [N-1:0] e, input logic [N-1:0] m,
                            input logic [N-1:0] pt, output int acc_cyc);
    @(posedge clock); #1;
    key = k; e_data = e; in_valid = 1'b1; last_mac = m;
`ifdef MAC_CHECK_EN
    e_mac = m;
`endif
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (in_ready) break;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b, expected 1", in_ready);
    end
    @(posedge clock); #1;
    acc_cyc = cyc;
    in_valid = 1'b0; key = N'($urandom); e_data = N'($urandom);
    exp_q.push_back(pt);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid) break;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_timeout: out_valid=%b, expected 1", out_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || d_data !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b d_data=%h in_ready=%b, expected 0 00 1", out_valid, d_data, in_ready);
    end
`ifdef MAC_CHECK_EN
    checks++;
    if (mac_ok !== 1'b0) begin errors++; $display("FAIL reset_mac_ok: got %b, expected 0", mac_ok); end
`endif
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || d_data !== 8'h00 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_hold: cycle %0d out_valid=%b d_data=%h in_ready=%b, expected 0 00 1", i, out_valid, d_data, in_ready);
      end
    end
  endtask

  task automatic test_basic();
    int a, lat;
    out_ready = 1'b1;
    drive_word(8'h00, 8'hFD, 8'hFE, 8'h01, a);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); lat++;
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_in_ready: edge %0d in_ready=%b, expected 0", lat, in_ready);
      end
      if (out_valid) break;
    end
    checks++;
    if (lat != ROUNDS) begin errors++; $display("FAIL latency: got %0d edges, expected %0d", lat, ROUNDS); end
    checks++;
    if (d_data !== 8'h01) begin errors++; $display("FAIL basic_data: got %h, expected 01", d_data); end
    @(posedge clock); @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || d_data !== 8'h01) begin
      errors++;
      $display("FAIL release: out_valid=%b in_ready=%b d_data=%h, expected 0 1 01", out_valid, in_ready, d_data);
    end
  endtask

  task automatic test_backpressure();
    int a;
    @(posedge clock); #1 out_ready = 1'b0;
    drive_word(8'h0F, 8'h55, 8'hF2, 8'h02, a);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || d_data !== 8'h02) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d out_valid=%b d_data=%h, expected 1 02", i, out_valid, d_data);
      end
    end
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    @(posedge clock); @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || d_data !== 8'h02) begin
      errors++;
      $display("FAIL stall_release: out_valid=%b d_data=%h, expected 0 02", out_valid, d_data);
    end
  endtask

  task automatic test_churn();
    int a0, a1;
    logic [N-1:0] p2;
    p2 = '0;
    for (int p = 0; p < 256; p++) if (enc(N'(p), 8'h13) == 8'hFF) p2 = N'(p);
    out_ready = 1'b1;
    drive_word(8'h00, 8'hFD, 8'hFE, 8'h01, a0);
    @(posedge clock); #1;
    key = 8'h13; e_data = 8'hFF; in_valid = 1'b1;
`ifdef MAC_CHECK_EN
    e_mac = p2 ^ ~8'h13;
`endif
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (in_ready) break;
    end
    @(posedge clock); #1;
    a1 = cyc; in_valid = 1'b0;
    exp_q.push_back(p2);
    checks++;
    if (a1 - a0 != ROUNDS + 2) begin
      errors++;
      $display("FAIL churn_accept_gap: got %0d cycles, expected %0d", a1 - a0, ROUNDS + 2);
    end
    wait_valid();
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_run();
    int a;
    out_ready = 1'b1;
    drive_word(8'h00, 8'hFD, 8'hFE, 8'h01, a);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || d_data !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b d_data=%h in_ready=%b, expected 0 00 1", out_valid, d_data, in_ready);
    end
    exp_q.delete();
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    drive_word(8'h00, 8'hFD, 8'hFE, 8'h01, a);
    wait_valid();
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    int a, prev;
    logic [N-1:0] p, k;
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      p = N'($urandom); k = N'($urandom);
      if (i == 0) p = 8'h00;
      if (i == 1) begin p = 8'hFF; k = 8'hFF; end
      drive_word(k, enc(p, k), p ^ ~k, p, a);
      if (i > 0) begin
        checks++;
        if (a - prev != ROUNDS + 2) begin
          errors++;
          $display("FAIL throughput: word %0d gap %0d cycles, expected %0d", i, a - prev, ROUNDS + 2);
        end
      end
      prev = a;
    end
    wait_valid();
    @(posedge clock); #1;
  endtask

`ifdef MAC_CHECK_EN
  task automatic test_mac();
    int a;
    logic [N-1:0] kv[3], ev[3], mv[3], pv[3];
    logic         okv[3];
    kv = '{8'h0F, 8'h0F, 8'h00}; ev = '{8'h55, 8'h55, 8'hFD};
    mv = '{8'hF2, 8'hF3, 8'hFE}; pv = '{8'h02, 8'h02, 8'h01};
    okv = '{1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_word(kv[i], ev[i], mv[i], pv[i], a);
      wait_valid();
      checks++;
      if (mac_ok !== okv[i] || d_data !== pv[i]) begin
        errors++;
        $display("FAIL mac_case%0d: mac_ok=%b d_data=%h, expected %b %h", i, mac_ok, d_data, okv[i], pv[i]);
      end
      @(posedge clock); @(negedge clock);
      checks++;
      if (mac_ok !== 1'b0) begin errors++; $display("FAIL mac_clear%0d: mac_ok=%b, expected 0", i, mac_ok); end
    end
  endtask
`endif

  task automatic test_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d words never delivered, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_churn();
    test_reset_mid_run();
    test_back_to_back();
`ifdef MAC_CHECK_EN
    test_mac();
`endif
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
